// File: rtl/irq_encoder8_3_pkg.sv
// Shared constants and the code-to-line mapping used by the active-low
// 3-to-8 decoder and by the 8-to-3 interrupt encoder.
package irq_encoder8_3_pkg;

  localparam int           N_REQ    = 8;
  localparam int           CODE_W   = 3;
  localparam logic [7:0]   IDLE_REQ = 8'hFF;

  // Code k is carried on request line 7-k.
  function automatic logic [CODE_W-1:0] code_to_bit(input logic [CODE_W-1:0] k);
    return 3'd7 - k;
  endfunction

endpackage

// File: rtl/irq_encoder8_3_prio_pick8.sv
// Combinational priority pick over eight candidates held in code order
// (bit k = code k). Returns the winning code and an any-set flag.
module irq_encoder8_3_prio_pick8
  import irq_encoder8_3_pkg::*;
#(
  parameter bit PRIO_LOW_FIRST = 1'b1
) (
  input  logic [N_REQ-1:0]  i_cand,
  output logic [CODE_W-1:0] o_idx,
  output logic              o_any
);

  // Scan so that the last hit is the winner for the selected priority order.
  always_comb begin
    o_idx = '0;
    o_any = |i_cand;
    if (PRIO_LOW_FIRST) begin
      for (int i = N_REQ - 1; i >= 0; i--) begin
        if (i_cand[i]) o_idx = CODE_W'(i);
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (i_cand[i]) o_idx = CODE_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_encoder8_3.sv
// Sequential 8-to-3 interrupt encoder. Falling edges on active-low request
// lines become sticky pending bits; the highest-priority pending code is
// presented with a valid/ack handshake and held stable until acknowledged.
module irq_encoder8_3
  import irq_encoder8_3_pkg::*;
#(
  parameter bit PRIO_LOW_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_REQ-1:0]  req_n,
  input  logic              g1,
  input  logic              g2a,
  input  logic              g2b,
  input  logic              ack,
  output logic [CODE_W-1:0] code,
  output logic              valid,
  output logic [N_REQ-1:0]  pending_n
);

  // Line-order history of req_n; pending and candidates are kept in code order.
  logic [N_REQ-1:0]  r_req_q;
  logic [N_REQ-1:0]  r_pend;
  logic [CODE_W-1:0] r_code;
  logic              r_valid;

  logic              w_en;
  logic [N_REQ-1:0]  w_fall;
  logic [N_REQ-1:0]  w_set;
  logic [N_REQ-1:0]  w_clr;
  logic [N_REQ-1:0]  w_cand;
  logic [N_REQ-1:0]  w_pend_nxt;
  logic              w_load;
  logic [CODE_W-1:0] w_idx;
  logic              w_any;

  // Edge detect, set/clear masks and the candidate set for the next load.
  always_comb begin
    w_en   = g1 & ~g2a & ~g2b;
    w_fall = r_req_q & ~req_n;
    w_set  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_set[k] = w_fall[code_to_bit(CODE_W'(k))] & w_en;
    end
    w_clr      = (r_valid & ack) ? (N_REQ'(1) << r_code) : '0;
    // Set wins over clear when both hit the same bit on one edge.
    w_pend_nxt = (r_pend & ~w_clr) | w_set;
    // Same-edge falls are excluded: candidates come from the current register.
    w_cand     = r_pend & ~w_clr;
    w_load     = ~r_valid | ack;
  end

  irq_encoder8_3_prio_pick8 #(
    .PRIO_LOW_FIRST (PRIO_LOW_FIRST)
  ) u_pick (
    .i_cand (w_cand),
    .o_idx  (w_idx),
    .o_any  (w_any)
  );

  // State registers: request history, pending bits and the presented code.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_req_q <= IDLE_REQ;
      r_pend  <= '0;
      r_code  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_req_q <= req_n;
      r_pend  <= w_pend_nxt;
      if (w_load) begin
        if (w_any) begin
          r_code  <= w_idx;
          r_valid <= 1'b1;
        end else begin
          r_valid <= 1'b0;
        end
      end
    end
  end

  // Present the pending register back in request-line order, active low.
  always_comb begin
    pending_n = '1;
    for (int k = 0; k < N_REQ; k++) begin
      pending_n[code_to_bit(CODE_W'(k))] = ~r_pend[k];
    end
  end

  assign code  = r_code;
  assign valid = r_valid;

endmodule

// File: tb/tb_irq_encoder8_3.sv
// Directed bench for irq_encoder8_3: a low-first instance and a high-first
// instance share stimulus; expected values are hand-computed per step.
module tb_irq_encoder8_3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req_n;
  logic       g1, g2a, g2b, ack;
  logic [2:0] code_lo, code_hi;
  logic       valid_lo, valid_hi;
  logic [7:0] pn_lo, pn_hi;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  irq_encoder8_3 #(.PRIO_LOW_FIRST(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_n(req_n), .g1(g1), .g2a(g2a), .g2b(g2b),
    .ack(ack), .code(code_lo), .valid(valid_lo), .pending_n(pn_lo)
  );

  irq_encoder8_3 #(.PRIO_LOW_FIRST(1'b0)) u_dut_hi (
    .clk(clk), .rst_n(rst_n), .req_n(req_n), .g1(g1), .g2a(g2a), .g2b(g2b),
    .ack(ack), .code(code_hi), .valid(valid_hi), .pending_n(pn_hi)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; req_n = 8'hFF; g1 = 1'b1; g2a = 1'b0; g2b = 1'b0; ack = 1'b0;
    tick(); tick();
    check("rst_valid", {7'd0, valid_lo}, 8'h00);
    check("rst_code",  {5'd0, code_lo},  8'h00);
    check("rst_pn",    pn_lo,            8'hFF);
    rst_n = 1'b1;

    // Single request on line 3 -> code 4, two-edge latency.
    req_n = 8'b1111_0111;
    tick();
    check("t1_valid_e1", {7'd0, valid_lo}, 8'h00);
    check("t1_pn_e1",    pn_lo,            8'hF7);
    tick();
    check("t1_valid", {7'd0, valid_lo}, 8'h01);
    check("t1_code",  {5'd0, code_lo},  8'h04);
    ack = 1'b1; tick(); ack = 1'b0;
    check("t1_ack_valid", {7'd0, valid_lo}, 8'h00);
    check("t1_ack_pn",    pn_lo,            8'hFF);
    req_n = 8'hFF; tick();

    // Codes 0 and 7 together; order depends on priority direction.
    req_n = 8'b0111_1110;
    tick(); tick();
    check("t2_code_lo", {5'd0, code_lo}, 8'h00);
    check("t2_code_hi", {5'd0, code_hi}, 8'h07);
    check("t2_pn_hi",   pn_hi,           8'h7E);
    tick();
    check("t2_stable", {5'd0, code_lo}, 8'h00);
    ack = 1'b1; tick();
    check("t2_next_lo",  {5'd0, code_lo},  8'h07);
    check("t2_held_lo",  {7'd0, valid_lo}, 8'h01);
    check("t2_next_hi",  {5'd0, code_hi},  8'h00);
    tick(); ack = 1'b0;
    check("t2_drain_lo", {7'd0, valid_lo}, 8'h00);
    check("t2_drain_hi", {7'd0, valid_hi}, 8'h00);

    // Lines still held low: no re-arm until they return high.
    tick();
    check("t3_norearm_v",  {7'd0, valid_lo}, 8'h00);
    check("t3_norearm_pn", pn_lo,            8'hFF);
    req_n = 8'hFF; tick();
    req_n = 8'h7F; tick(); tick();
    check("t3_rearm_v", {7'd0, valid_lo}, 8'h01);
    check("t3_rearm_c", {5'd0, code_lo},  8'h00);
    ack = 1'b1; tick(); ack = 1'b0;
    req_n = 8'hFF; tick();

    // Fall on line 4 (code 3) coincident with the ack of code 3.
    req_n = 8'hEF; tick(); tick();
    check("t4_code", {5'd0, code_lo}, 8'h03);
    req_n = 8'hFF; tick();
    req_n = 8'hEF; ack = 1'b1; tick(); ack = 1'b0;
    check("t4_setwins_pn", pn_lo, 8'hEF);
    tick();
    check("t4_again_v", {7'd0, valid_lo}, 8'h01);
    check("t4_again_c", {5'd0, code_lo},  8'h03);
    ack = 1'b1; tick(); ack = 1'b0;
    check("t4_done_v", {7'd0, valid_lo}, 8'h00);
    req_n = 8'hFF; tick();

    // Disabled fall is discarded; re-enable with line still low captures nothing.
    g2a = 1'b1; req_n = 8'hDF; tick();
    check("t5_dis_pn", pn_lo, 8'hFF);
    g2a = 1'b0; tick(); tick();
    check("t5_reen_pn", pn_lo,            8'hFF);
    check("t5_reen_v",  {7'd0, valid_lo}, 8'h00);
    req_n = 8'hFF; tick();

    // Higher-priority code 1 arrives while code 5 is presented.
    req_n = 8'hFB; tick(); tick();
    check("t6_code5", {5'd0, code_lo}, 8'h05);
    req_n = 8'hBB; tick(); tick();
    check("t6_nopreempt", {5'd0, code_lo}, 8'h05);
    check("t6_pn",        pn_lo,           8'hBB);
    ack = 1'b1; tick();
    check("t6_code1", {5'd0, code_lo},  8'h01);
    check("t6_v1",    {7'd0, valid_lo}, 8'h01);
    tick(); ack = 1'b0;
    check("t6_drain", {7'd0, valid_lo}, 8'h00);
    req_n = 8'hFF; tick();

    // Reset mid-handshake with three pending bits.
    req_n = 8'h9E; tick(); tick();
    check("t7_pre_c",  {5'd0, code_lo}, 8'h01);
    check("t7_pre_pn", pn_lo,           8'h9E);
    rst_n = 1'b0; tick();
    check("t7_rst_v",  {7'd0, valid_lo}, 8'h00);
    check("t7_rst_c",  {5'd0, code_lo},  8'h00);
    check("t7_rst_pn", pn_lo,            8'hFF);
    rst_n = 1'b1; req_n = 8'hFF; tick(); tick();
    check("t7_post_v", {7'd0, valid_lo}, 8'h00);
    req_n = 8'hFD; tick(); tick();
    check("t7_toggle_c", {5'd0, code_lo},  8'h06);
    check("t7_toggle_v", {7'd0, valid_lo}, 8'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
